// File: rtl/barrel_pkg.sv
// Shared types and helpers for the barrel rotator: rotate direction encoding and
// the bit-reversal function used by both the pre- and post-reversal stages.
package barrel_pkg;

  typedef enum logic {
    ROTATE_LEFT  = 1'b0,
    ROTATE_RIGHT = 1'b1
  } dir_e;

  // Widest operand bit_rev can handle; callers zero-extend into this width.
  localparam int BIT_REV_MAX_W = 64;

  // Reverses the low 'width' bits of x; bits at or above 'width' come back as zero.
  function automatic logic [BIT_REV_MAX_W-1:0] bit_rev(
    input logic [BIT_REV_MAX_W-1:0] x,
    input int                       width
  );
    logic [BIT_REV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BIT_REV_MAX_W; i++) begin
      if (i < width) r[i] = x[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_rotl.sv
// Combinational log-stage left rotator: stage k rotates left by 2^k when amt_i[k] is set.
module barrel_rotl #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage [AMT_W+1];

  assign stage[0] = data_i;

  for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
    localparam int SH = 1 << gi;
    assign stage[gi+1] = amt_i[gi]
                       ? {stage[gi][WIDTH-SH-1:0], stage[gi][WIDTH-1:WIDTH-SH]}
                       : stage[gi];
  end

  assign data_o = stage[AMT_W];

endmodule

// File: rtl/barrel_shifter_multi_rev.sv
// Registered bidirectional barrel rotator; right rotates reuse the left core via bit reversal.
// Define BARREL_PIPE_EN to add a pipe register after the core (latency 2 instead of 1).
import barrel_pkg::*;

module barrel_shifter_multi_rev #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir_lr,
  output logic [WIDTH-1:0] out
);

  logic                           is_right;
  logic [BIT_REV_MAX_W-WIDTH-1:0] pre_rev_pad_unused;
  logic [BIT_REV_MAX_W-WIDTH-1:0] post_rev_pad_unused;
  logic [WIDTH-1:0]               pre_rev;
  logic [WIDTH-1:0]               rotl_in;
  logic [WIDTH-1:0]               rotl_out;
  logic [WIDTH-1:0]               post_in;
  logic                           post_right;
  logic [WIDTH-1:0]               post_rev;
  logic [WIDTH-1:0]               out_d;
  logic [WIDTH-1:0]               out_q;

  assign is_right = (dir_lr == ROTATE_RIGHT);

  assign {pre_rev_pad_unused, pre_rev} = bit_rev(BIT_REV_MAX_W'(data), WIDTH);
  assign rotl_in = is_right ? pre_rev : data;

  barrel_rotl #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_rotl (
    .data_i (rotl_in),
    .amt_i  (amt),
    .data_o (rotl_out)
  );

`ifdef BARREL_PIPE_EN
  // Direction travels with the rotated data so the post-reversal matches its operand.
  logic [WIDTH-1:0] pipe_q;
  logic             pipe_right_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q       <= '0;
      pipe_right_q <= 1'b0;
    end else begin
      pipe_q       <= rotl_out;
      pipe_right_q <= is_right;
    end
  end

  assign post_in    = pipe_q;
  assign post_right = pipe_right_q;
`else
  assign post_in    = rotl_out;
  assign post_right = is_right;
`endif

  assign {post_rev_pad_unused, post_rev} = bit_rev(BIT_REV_MAX_W'(post_in), WIDTH);
  assign out_d = post_right ? post_rev : post_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out = out_q;

  property p_ctrl_known;
    @(posedge clk) disable iff (!rst_n) !$isunknown({dir_lr, amt});
  endproperty
  a_ctrl_known: assert property (p_ctrl_known);

endmodule

// File: tb/tb_barrel_shifter_multi_rev.sv
// Self-checking bench for barrel_shifter_multi_rev: directed sweeps plus random ops,
// scored against an arithmetic rotate model; latency follows BARREL_PIPE_EN.
module tb_barrel_shifter_multi_rev;

`ifdef BARREL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic [2:0] amt;
  logic       dir_lr;
  logic [7:0] out;

  int tests_run;
  int tests_failed;

  logic [7:0] exp_q [$];
  int         pop_q [$];

  barrel_shifter_multi_rev #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .amt    (amt),
    .dir_lr (dir_lr),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Rotation by plain arithmetic on an integer; amount taken modulo 8.
  function automatic logic [7:0] ref_rot(input logic [7:0] d, input int a, input logic right);
    int v;
    int s;
    v = int'(d);
    s = a % 8;
    if (!right) return 8'(((v << s) | (v >> (8 - s))) & 255);
    else        return 8'(((v >> s) | (v << (8 - s))) & 255);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s: %0h", tag, got);
    end
  endtask

  // Results still inside the pipe after reset are zeros.
  task automatic reset_scoreboard();
    exp_q.delete();
    pop_q.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      exp_q.push_back(8'h00);
      pop_q.push_back(0);
    end
  endtask

  // Drive one operation, let it be captured, then score whichever result is due now.
  task automatic step(input string tag, input logic [7:0] d, input int a, input logic right);
    logic [7:0] e;
    int         p;
    data   = d;
    amt    = 3'(a);
    dir_lr = right;
    exp_q.push_back(ref_rot(d, a, right));
    pop_q.push_back($countones(d));
    @(posedge clk);
    #1;
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      p = pop_q.pop_front();
      check_eq(tag, 32'(out), 32'(e));
      check_eq({tag, "_pop"}, 32'($countones(out)), 32'(p));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n  = 1'b0;
    data   = 8'hFF;
    amt    = 3'd0;
    dir_lr = 1'b0;

    #3;
    check_eq("rst_async", 32'(out), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_held", 32'(out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_scoreboard();

    step("rst_first", 8'hFF, 0, 1'b0);
    step("rst_first2", 8'hFF, 0, 1'b0);

    for (int a = 0; a < 8; a++) step($sformatf("left_%0d", a), 8'h01, a, 1'b0);
    for (int a = 0; a < 8; a++) step($sformatf("right_%0d", a), 8'h01, a, 1'b1);

    step("a5_l3", 8'hA5, 3, 1'b0);
    step("a5_r3", 8'hA5, 3, 1'b1);
    step("a5_r0", 8'hA5, 0, 1'b1);

    for (int i = 0; i < 30; i++)
      step($sformatf("rnd_%0d", i), 8'($urandom), int'($urandom_range(0, 7)), 1'(i % 2));

    // Mid-stream reset: output clears at once and nothing in flight survives.
    data   = 8'hC3;
    amt    = 3'd1;
    dir_lr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_async", 32'(out), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_rst_held", 32'(out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_scoreboard();

    for (int i = 0; i < 12; i++)
      step($sformatf("post_rst_%0d", i), 8'($urandom), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
